// File: rtl/regfile_sb.sv
// Integer register file with hardwired x0, optional write-to-read forwarding,
// a post-reset clear sweep (one register per cycle) and a pending-write
// scoreboard for long-latency functional units.
module regfile_sb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter bit          BYPASS = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(NREG)-1:0]  waddr,
  input  logic [XLEN-1:0]          wdata,
  input  logic [$clog2(NREG)-1:0]  raddr1,
  input  logic [$clog2(NREG)-1:0]  raddr2,
  output logic [XLEN-1:0]          rdata1,
  output logic [XLEN-1:0]          rdata2,
  input  logic                     rsv_en,
  input  logic [$clog2(NREG)-1:0]  rsv_rd,
  output logic                     busy1,
  output logic                     busy2,
  output logic                     ready
);

  localparam int unsigned AW = $clog2(NREG);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t            state;
  logic [AW-1:0]     clr_idx;
  logic [NREG-1:0]   sb;
  logic [NREG-1:0]   sb_next;
  logic [XLEN-1:0]   mem [NREG];

  logic              run;
  logic              wr_en;
  logic [AW-1:0]     wr_idx;
  logic [XLEN-1:0]   wr_val;

  assign run = (state == RUN);

  // Sweep sequencer: CLEAR walks every index once, then hands over to RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
      ready   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + AW'(1);
          if (clr_idx == AW'(NREG - 1)) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          state <= RUN;
        end
        default: begin
          state   <= CLEAR;
          clr_idx <= '0;
          ready   <= 1'b0;
        end
      endcase
    end
  end

  // Single array write port shared by the clear sweep and writeback
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = '0;
    wr_val = '0;
    if (!rst) begin
      if (!run) begin
        wr_en  = 1'b1;
        wr_idx = clr_idx;
        wr_val = '0;
      end else if (we && (waddr != '0)) begin
        wr_en  = 1'b1;
        wr_idx = waddr;
        wr_val = wdata;
      end
    end
  end

  // Storage array; no reset, the sweep zeroes it instead
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_val;
    end
  end

  // Scoreboard update: writeback clears first so a same-index reserve wins
  always_comb begin
    sb_next = sb;
    if (we) begin
      sb_next[waddr] = 1'b0;
    end
    if (rsv_en && (rsv_rd != '0)) begin
      sb_next[rsv_rd] = 1'b1;
    end
    sb_next[0] = 1'b0;
  end

  // Scoreboard register; frozen (and zero) during the sweep
  always_ff @(posedge clk) begin
    if (rst) begin
      sb <= '0;
    end else if (run) begin
      sb <= sb_next;
    end
  end

  // Read mux: zero while clearing or for x0, optional same-cycle forward
  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
    logic [XLEN-1:0] val;
    val = '0;
    if (run && (addr != '0)) begin
      if (BYPASS && we && (waddr == addr)) begin
        val = wdata;
      end else begin
        val = mem[addr];
      end
    end
    return val;
  endfunction

  // Combinational read ports and busy flags
  always_comb begin
    rdata1 = read_port(raddr1);
    rdata2 = read_port(raddr2);
    busy1  = run & sb[raddr1];
    busy2  = run & sb[raddr2];
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: a driver applies stimulus and queues the
// expected outputs from an array-based model; a monitor pops and compares at
// the falling edge. A BYPASS=0 copy shares the inputs to check non-forwarding.
module tb_regfile_sb;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;

  logic            clk;
  logic            rst;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [XLEN-1:0] wdata;
  logic [AW-1:0]   raddr1;
  logic [AW-1:0]   raddr2;
  logic            rsv_en;
  logic [AW-1:0]   rsv_rd;

  logic [XLEN-1:0] rdata1, rdata2, nb_rdata1, nb_rdata2;
  logic            busy1, busy2, ready, nb_busy1, nb_busy2, nb_ready;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .rsv_en(rsv_en), .rsv_rd(rsv_rd), .busy1(busy1), .busy2(busy2),
    .ready(ready)
  );

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(nb_rdata1), .rdata2(nb_rdata2),
    .rsv_en(rsv_en), .rsv_rd(rsv_rd), .busy1(nb_busy1), .busy2(nb_busy2),
    .ready(nb_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            rdy;
    logic [XLEN-1:0] r1, r2, n1, n2;
    logic            b1, b2;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state (post-edge view)
  logic [XLEN-1:0] m_mem [NREG];
  bit              m_sb  [NREG];
  bit              m_ready;
  int              m_left;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] mread(input logic [AW-1:0] a, input bit byp,
                                            input logic w, input logic [AW-1:0] wa,
                                            input logic [XLEN-1:0] wd);
    if (!m_ready || a == 0) return '0;
    if (byp && w && wa == a) return wd;
    return m_mem[a];
  endfunction

  task automatic step(input logic r, input logic w, input logic [AW-1:0] wa,
                      input logic [XLEN-1:0] wd, input logic [AW-1:0] a1,
                      input logic [AW-1:0] a2, input logic rv, input logic [AW-1:0] rr);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; we = w; waddr = wa; wdata = wd;
    raddr1 = a1; raddr2 = a2; rsv_en = rv; rsv_rd = rr;
    e.rdy = m_ready;
    e.r1  = mread(a1, 1'b1, w, wa, wd);
    e.r2  = mread(a2, 1'b1, w, wa, wd);
    e.n1  = mread(a1, 1'b0, w, wa, wd);
    e.n2  = mread(a2, 1'b0, w, wa, wd);
    e.b1  = m_ready && m_sb[a1];
    e.b2  = m_ready && m_sb[a2];
    exp_q.push_back(e);
    // Advance model across the coming edge
    if (r) begin
      m_ready = 1'b0;
      m_left  = NREG;
      for (int i = 0; i < NREG; i++) begin
        m_mem[i] = '0;
        m_sb[i]  = 1'b0;
      end
    end else if (!m_ready) begin
      m_left--;
      if (m_left == 0) m_ready = 1'b1;
    end else begin
      if (w && wa != 0) m_mem[wa] = wd;
      if (w) m_sb[wa] = 1'b0;
      if (rv && rr != 0) m_sb[rr] = 1'b1;
    end
  endtask

  task automatic rd(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    step(1'b0, 1'b0, '0, '0, a1, a2, 1'b0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                    input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    step(1'b0, 1'b1, wa, wd, a1, a2, 1'b0, '0);
  endtask

  task automatic rsv(input logic [AW-1:0] rr, input logic [AW-1:0] a1);
    step(1'b0, 1'b0, '0, '0, a1, a1, 1'b1, rr);
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREG - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  // Monitor: compare every presented cycle against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ready",     {31'b0, ready},    {31'b0, e.rdy});
        chk("rdata1",    rdata1,            e.r1);
        chk("rdata2",    rdata2,            e.r2);
        chk("nb_rdata1", nb_rdata1,         e.n1);
        chk("nb_rdata2", nb_rdata2,         e.n2);
        chk("busy1",     {31'b0, busy1},    {31'b0, e.b1});
        chk("busy2",     {31'b0, busy2},    {31'b0, e.b2});
        chk("nb_busy1",  {31'b0, nb_busy1}, {31'b0, e.b1});
      end
    end
  end

  // Driver
  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    raddr1 = '0; raddr2 = '0; rsv_en = 1'b0; rsv_rd = '0;
    m_ready = 1'b0;
    m_left  = NREG;
    for (int i = 0; i < NREG; i++) begin
      m_mem[i] = '0;
      m_sb[i]  = 1'b0;
    end

    // Reset sweep, with a write attempt mid-sweep
    step(1'b1, 1'b0, '0, '0, 5, 31, 1'b0, '0);
    step(1'b1, 1'b0, '0, '0, 5, 31, 1'b0, '0);
    for (int i = 0; i < NREG; i++)
      step(1'b0, (i == 10), 7, 32'h55, 5, 31, (i == 12), 9);
    rd(7, 5);
    rd(31, 7);

    // Reset from RUN, then again mid-sweep
    wr(3, 32'hDEAD, 0, 0);
    rd(3, 3);
    step(1'b1, 1'b0, '0, '0, 3, 3, 1'b0, '0);
    for (int i = 0; i < 20; i++) rd(3, 7);
    step(1'b1, 1'b0, '0, '0, 3, 3, 1'b0, '0);
    for (int i = 0; i < NREG; i++) rd(3, 0);
    rd(3, 7);

    // Writes with x0
    wr(3, 32'h1234_5678, 0, 0);
    wr(0, 32'hFFFF_FFFF, 3, 0);
    rd(3, 0);
    rd(3, 3);
    rd(0, 0);

    // Forwarding vs. no forwarding
    wr(9, 32'h1111_1111, 0, 0);
    step(1'b0, 1'b1, 9, 32'hA5A5_A5A5, 9, 9, 1'b0, '0);
    rd(9, 9);

    // Scoreboard basics
    rsv(12, 12);
    rd(12, 12);
    wr(12, 32'hC0DE, 12, 12);
    rd(12, 12);
    rsv(0, 0);
    rd(0, 12);

    // Simultaneous reserve/writeback
    rsv(4, 4);
    step(1'b0, 1'b1, 4, 32'h44, 4, 4, 1'b1, 4);
    rd(4, 4);
    rsv(8, 8);
    step(1'b0, 1'b1, 8, 32'h88, 6, 8, 1'b1, 6);
    rd(6, 8);
    step(1'b1, 1'b0, '0, '0, 6, 6, 1'b0, '0);
    for (int i = 0; i < NREG; i++) rd(6, 8);
    rd(6, 6);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1),
           rnd_addr(), $urandom(), rnd_addr(), rnd_addr(),
           ($urandom_range(0, 2) == 0), rnd_addr());
    end
    rd(0, 0);

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", XLEN'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
